// File: rtl/ysyx_23060075_trap_ctrl_pkg.sv
// Shared constants for the trap/CSR sequencer.
// Holds CSR addresses, request op encodings, mstatus fields and the FSM state type.
package ysyx_23060075_trap_ctrl_pkg;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;

    localparam logic [2:0] OP_CSRRW = 3'd0;
    localparam logic [2:0] OP_CSRRS = 3'd1;
    localparam logic [2:0] OP_CSRRC = 3'd2;
    localparam logic [2:0] OP_ECALL = 3'd4;
    localparam logic [2:0] OP_MRET  = 3'd5;

    localparam int MS_MIE    = 3;
    localparam int MS_MPIE   = 7;
    localparam int MS_MPP_LO = 11;
    localparam int MS_MPP_HI = 12;

    typedef enum logic [3:0] {
        S_IDLE,
        S_ZICSR,
        S_EC_MEPC,
        S_EC_MCAUSE,
        S_EC_MSTATUS,
        S_EC_MTVEC,
        S_MR_MSTATUS,
        S_MR_MEPC,
        S_DONE
    } state_e;

endpackage

// File: rtl/ysyx_23060075_trap_ctrl_if.sv
// Request/response bundle between the datapath and the trap sequencer.
// master = datapath side, slave = sequencer side.
interface ysyx_23060075_trap_ctrl_if #(
    parameter int ISA_WIDTH      = 32,
    parameter int CSR_ADDR_WIDTH = 12
);
    logic                      req_valid;
    logic                      req_ready;
    logic [2:0]                req_op;
    logic [ISA_WIDTH-1:0]      req_pc;
    logic [ISA_WIDTH-1:0]      req_src;
    logic                      req_src_zero;
    logic [CSR_ADDR_WIDTH-1:0] req_csr_addr;
    logic                      done;
    logic [ISA_WIDTH-1:0]      rd_data;
    logic                      redirect;
    logic [ISA_WIDTH-1:0]      next_pc;
    logic                      illegal;

    modport master (
        output req_valid, req_op, req_pc, req_src,
        output req_src_zero, req_csr_addr,
        input  req_ready, done, rd_data, redirect,
        input  next_pc, illegal
    );

    modport slave (
        input  req_valid, req_op, req_pc, req_src,
        input  req_src_zero, req_csr_addr,
        output req_ready, done, rd_data, redirect,
        output next_pc, illegal
    );
endinterface

// File: rtl/ysyx_23060075_trap_ctrl.sv
// CSR access sequencer for Zicsr ops, ECALL entry and MRET return.
// Drives the single-port CSR file one access per cycle.
module ysyx_23060075_trap_ctrl
    import ysyx_23060075_trap_ctrl_pkg::*;
#(
    parameter int ISA_WIDTH      = 32,
    parameter int CSR_ADDR_WIDTH = 12,
    parameter int ECALL_CAUSE    = 11
) (
    input  logic                      clk,
    input  logic                      rst,
    ysyx_23060075_trap_ctrl_if.slave  req,
    output logic [CSR_ADDR_WIDTH-1:0] csr_addr,
    output logic [ISA_WIDTH-1:0]      csr_w,
    output logic                      csr_w_en,
    input  logic [ISA_WIDTH-1:0]      csr_r
);

    state_e                    state_q, state_d;
    logic [2:0]                op_q, op_d;
    logic [ISA_WIDTH-1:0]      pc_q, pc_d;
    logic [ISA_WIDTH-1:0]      src_q, src_d;
    logic                      zero_q, zero_d;
    logic [CSR_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [ISA_WIDTH-1:0]      rd_data_q, rd_data_d;
    logic [ISA_WIDTH-1:0]      next_pc_q, next_pc_d;
    logic                      redir_q, redir_d;
    logic                      ill_q, ill_d;
    logic [ISA_WIDTH-1:0]      ms_ecall, ms_mret;
    logic                      is_zicsr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            op_q      <= '0;
            pc_q      <= '0;
            src_q     <= '0;
            zero_q    <= 1'b0;
            addr_q    <= '0;
            rd_data_q <= '0;
            next_pc_q <= '0;
            redir_q   <= 1'b0;
            ill_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            pc_q      <= pc_d;
            src_q     <= src_d;
            zero_q    <= zero_d;
            addr_q    <= addr_d;
            rd_data_q <= rd_data_d;
            next_pc_q <= next_pc_d;
            redir_q   <= redir_d;
            ill_q     <= ill_d;
        end
    end

    // Trap entry stacks MIE into MPIE; return restores it. MPP stays M-mode.
    always_comb begin
        ms_ecall                       = csr_r;
        ms_ecall[MS_MPIE]              = csr_r[MS_MIE];
        ms_ecall[MS_MIE]               = 1'b0;
        ms_ecall[MS_MPP_HI:MS_MPP_LO]  = 2'b11;
        ms_mret                        = csr_r;
        ms_mret[MS_MIE]                = csr_r[MS_MPIE];
        ms_mret[MS_MPIE]               = 1'b1;
        ms_mret[MS_MPP_HI:MS_MPP_LO]   = 2'b11;
    end

    assign is_zicsr = (req.req_op == OP_CSRRW) ||
                      (req.req_op == OP_CSRRS) ||
                      (req.req_op == OP_CSRRC);

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        pc_d      = pc_q;
        src_d     = src_q;
        zero_d    = zero_q;
        addr_d    = addr_q;
        rd_data_d = rd_data_q;
        next_pc_d = next_pc_q;
        redir_d   = redir_q;
        ill_d     = ill_q;
        csr_addr  = '0;
        csr_w     = '0;
        csr_w_en  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (req.req_valid) begin
                    op_d    = req.req_op;
                    pc_d    = req.req_pc;
                    src_d   = req.req_src;
                    zero_d  = req.req_src_zero;
                    addr_d  = req.req_csr_addr;
                    redir_d = 1'b0;
                    ill_d   = 1'b0;
                    unique case (1'b1)
                        is_zicsr: state_d = S_ZICSR;
                        (req.req_op == OP_ECALL): begin
                            state_d = S_EC_MEPC;
                            redir_d = 1'b1;
                        end
                        (req.req_op == OP_MRET): begin
                            state_d = S_MR_MSTATUS;
                            redir_d = 1'b1;
                        end
                        default: begin
                            state_d   = S_DONE;
                            ill_d     = 1'b1;
                            rd_data_d = '0;
                        end
                    endcase
                end
            end
            S_ZICSR: begin
                csr_addr  = addr_q;
                rd_data_d = csr_r;
                state_d   = S_DONE;
                if (op_q == OP_CSRRW) begin
                    csr_w    = src_q;
                    csr_w_en = 1'b1;
                end else if (op_q == OP_CSRRS) begin
                    csr_w    = csr_r | src_q;
                    csr_w_en = ~zero_q;
                end else begin
                    csr_w    = csr_r & ~src_q;
                    csr_w_en = ~zero_q;
                end
            end
            S_EC_MEPC: begin
                csr_addr = CSR_ADDR_WIDTH'(CSR_MEPC);
                csr_w    = pc_q;
                csr_w_en = 1'b1;
                state_d  = S_EC_MCAUSE;
            end
            S_EC_MCAUSE: begin
                csr_addr = CSR_ADDR_WIDTH'(CSR_MCAUSE);
                csr_w    = ISA_WIDTH'(ECALL_CAUSE);
                csr_w_en = 1'b1;
                state_d  = S_EC_MSTATUS;
            end
            S_EC_MSTATUS: begin
                csr_addr = CSR_ADDR_WIDTH'(CSR_MSTATUS);
                csr_w    = ms_ecall;
                csr_w_en = 1'b1;
                state_d  = S_EC_MTVEC;
            end
            S_EC_MTVEC: begin
                csr_addr  = CSR_ADDR_WIDTH'(CSR_MTVEC);
                next_pc_d = csr_r & ~(ISA_WIDTH'(3));
                rd_data_d = '0;
                state_d   = S_DONE;
            end
            S_MR_MSTATUS: begin
                csr_addr = CSR_ADDR_WIDTH'(CSR_MSTATUS);
                csr_w    = ms_mret;
                csr_w_en = 1'b1;
                state_d  = S_MR_MEPC;
            end
            S_MR_MEPC: begin
                csr_addr  = CSR_ADDR_WIDTH'(CSR_MEPC);
                next_pc_d = csr_r;
                rd_data_d = '0;
                state_d   = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign req.req_ready = (state_q == S_IDLE);
    assign req.done      = (state_q == S_DONE);
    assign req.redirect  = (state_q == S_DONE) & redir_q;
    assign req.illegal   = (state_q == S_DONE) & ill_q;
    assign req.rd_data   = rd_data_q;
    assign req.next_pc   = next_pc_q;

endmodule

// File: tb/tb_ysyx_23060075_trap_ctrl.sv
// Scoreboard bench for the trap/CSR sequencer with a small 4-entry CSR file model.
// Expected completions are queued at issue time and checked when done pulses.
module tb_ysyx_23060075_trap_ctrl;
    import ysyx_23060075_trap_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    ysyx_23060075_trap_ctrl_if ifc ();
    logic [11:0] csr_addr;
    logic [31:0] csr_w;
    logic [31:0] csr_r;
    logic        csr_w_en;

    ysyx_23060075_trap_ctrl dut (
        .clk      (clk),
        .rst      (rst),
        .req      (ifc),
        .csr_addr (csr_addr),
        .csr_w    (csr_w),
        .csr_w_en (csr_w_en),
        .csr_r    (csr_r)
    );

    logic [31:0] mepc    = 32'h0;
    logic [31:0] mcause  = 32'h0;
    logic [31:0] mtvec   = 32'h8000_0000;
    logic [31:0] mstatus = 32'h0;
    int wen_cnt = 0;
    int cyc_cnt = 0;
    int acc_cyc = 0;
    int done_cyc = 0;

    always_comb begin
        case (csr_addr)
            CSR_MEPC:    csr_r = mepc;
            CSR_MCAUSE:  csr_r = mcause;
            CSR_MTVEC:   csr_r = mtvec;
            CSR_MSTATUS: csr_r = mstatus;
            default:     csr_r = 32'h0;
        endcase
    end

    always @(posedge clk) begin
        cyc_cnt <= cyc_cnt + 1;
        if (ifc.req_valid && ifc.req_ready && rst) acc_cyc <= cyc_cnt;
        if (csr_w_en) begin
            wen_cnt <= wen_cnt + 1;
            case (csr_addr)
                CSR_MEPC:    mepc    <= csr_w;
                CSR_MCAUSE:  mcause  <= csr_w;
                CSR_MTVEC:   mtvec   <= csr_w;
                CSR_MSTATUS: mstatus <= csr_w;
                default: ;
            endcase
        end
    end

    typedef struct {
        logic [31:0] rd;
        logic [31:0] npc;
        logic        redir;
        logic        ill;
        logic        chk_npc;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int total = 0;
    int bad = 0;

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic exp_t mk(logic [31:0] rd, logic redir, logic [31:0] npc,
                                logic ill, logic chk_npc, int lat);
        exp_t e;
        e.rd = rd; e.redir = redir; e.npc = npc;
        e.ill = ill; e.chk_npc = chk_npc; e.lat = lat;
        return e;
    endfunction

    always @(negedge clk) begin : mon
        exp_t e;
        if (rst && ifc.done) begin
            done_cyc = cyc_cnt;
            if (sb.size() == 0) begin
                chk("sb_underflow", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("rd_data", ifc.rd_data, e.rd);
                chk("redirect", 32'(ifc.redirect), 32'(e.redir));
                chk("illegal", 32'(ifc.illegal), 32'(e.ill));
                chk("latency", 32'(cyc_cnt - acc_cyc), 32'(e.lat));
                if (e.chk_npc) chk("next_pc", ifc.next_pc, e.npc);
            end
        end
    end

    task automatic send(logic [2:0] op, logic [31:0] pc, logic [31:0] src,
                        logic zero, logic [11:0] addr, exp_t e, bit hold);
        int n;
        sb.push_back(e);
        @(negedge clk);
        ifc.req_valid    = 1'b1;
        ifc.req_op       = op;
        ifc.req_pc       = pc;
        ifc.req_src      = src;
        ifc.req_src_zero = zero;
        ifc.req_csr_addr = addr;
        n = 0;
        while (!ifc.req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n == 20) chk("accept_timeout", 32'd0, 32'd1);
        @(negedge clk);
        if (!hold) ifc.req_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 30) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            chk("done_timeout", 32'(sb.size()), 32'd0);
            sb.delete();
        end
        @(negedge clk);
    endtask

    task automatic zicsr(string tag, logic [2:0] op, logic [11:0] addr,
                         logic [31:0] src, logic zero, logic [31:0] rd, int wen);
        int w0;
        w0 = wen_cnt;
        send(op, 32'h0, src, zero, addr, mk(rd, 1'b0, 32'h0, 1'b0, 1'b0, 2), 1'b0);
        drain();
        chk(tag, 32'(wen_cnt - w0), 32'(wen));
    endtask

    initial begin
        int w0;
        ifc.req_valid    = 1'b0;
        ifc.req_op       = 3'd0;
        ifc.req_pc       = 32'h0;
        ifc.req_src      = 32'h0;
        ifc.req_src_zero = 1'b0;
        ifc.req_csr_addr = 12'h0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_ready", 32'(ifc.req_ready), 32'd1);
        chk("rst_done", 32'(ifc.done), 32'd0);
        chk("rst_rd_data", ifc.rd_data, 32'h0);
        chk("rst_next_pc", ifc.next_pc, 32'h0);
        chk("rst_csr_addr", 32'(csr_addr), 32'h0);

        // ECALL aborted by reset while in EC_MCAUSE
        ifc.req_valid = 1'b1;
        ifc.req_op    = OP_ECALL;
        ifc.req_pc    = 32'h8000_0004;
        @(negedge clk);
        ifc.req_valid = 1'b0;
        @(negedge clk);
        chk("mid_ec_wen", 32'(csr_w_en), 32'd1);
        rst = 1'b0;
        #1;
        chk("arst_wen", 32'(csr_w_en), 32'd0);
        chk("arst_addr", 32'(csr_addr), 32'h0);
        chk("arst_w", csr_w, 32'h0);
        chk("arst_done", 32'(ifc.done), 32'd0);
        chk("arst_redir", 32'(ifc.redirect), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("arst_ready", 32'(ifc.req_ready), 32'd1);
        chk("arst_mepc", mepc, 32'h8000_0004);
        chk("arst_mcause", mcause, 32'h0);

        zicsr("rw_wen", OP_CSRRW, CSR_MTVEC, 32'hF0, 1'b0, 32'h8000_0000, 1);
        chk("rw_mtvec", mtvec, 32'hF0);
        zicsr("rs_wen", OP_CSRRS, CSR_MTVEC, 32'hF0, 1'b0, 32'hF0, 1);
        chk("rs_mtvec", mtvec, 32'hF0);
        zicsr("rs0_wen", OP_CSRRS, CSR_MTVEC, 32'hF0, 1'b1, 32'hF0, 0);
        zicsr("set_mtvec", OP_CSRRW, CSR_MTVEC, 32'h8000_0203, 1'b0, 32'hF0, 1);
        zicsr("set_mstat", OP_CSRRW, CSR_MSTATUS, 32'h8, 1'b0, 32'h0, 1);

        w0 = wen_cnt;
        send(OP_ECALL, 32'h8000_0104, 32'h0, 1'b0, 12'h0,
             mk(32'h0, 1'b1, 32'h8000_0200, 1'b0, 1'b1, 5), 1'b0);
        drain();
        chk("ec_wen", 32'(wen_cnt - w0), 32'd3);
        chk("ec_mepc", mepc, 32'h8000_0104);
        chk("ec_mcause", mcause, 32'd11);
        chk("ec_mstatus", mstatus, 32'h1880);

        zicsr("set_mepc", OP_CSRRW, CSR_MEPC, 32'h8000_0108, 1'b0, 32'h8000_0104, 1);
        w0 = wen_cnt;
        send(OP_MRET, 32'h0, 32'h0, 1'b0, 12'h0,
             mk(32'h0, 1'b1, 32'h8000_0108, 1'b0, 1'b1, 3), 1'b0);
        drain();
        chk("mret_wen", 32'(wen_cnt - w0), 32'd1);
        chk("mret_mstatus", mstatus, 32'h1888);

        // illegal op with req_valid held, next request right behind it
        w0 = wen_cnt;
        send(3'd7, 32'h0, 32'h0, 1'b0, 12'h0,
             mk(32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 1), 1'b1);
        chk("ill_wen", 32'(wen_cnt - w0), 32'd0);
        send(OP_CSRRS, 32'h0, 32'h0, 1'b1, CSR_MSTATUS,
             mk(32'h1888, 1'b0, 32'h0, 1'b0, 1'b0, 2), 1'b0);
        chk("b2b_gap", 32'(acc_cyc - done_cyc), 32'd1);
        drain();

        w0 = wen_cnt;
        send(OP_CSRRC, 32'h0, 32'hFFFF_FFFF, 1'b0, 12'h7C0,
             mk(32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 2), 1'b0);
        drain();
        chk("unm_wen", 32'(wen_cnt - w0), 32'd1);
        chk("unm_mepc", mepc, 32'h8000_0108);
        chk("unm_mcause", mcause, 32'd11);
        chk("unm_mtvec", mtvec, 32'h8000_0203);
        chk("unm_mstatus", mstatus, 32'h1888);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
